// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial WIDTH-bit add/sub sequencer over one 8-bit lookahead slice.
// Optional abort input enabled by defining BSA_ABORT_EN.
module byte_serial_add_ctrl #(
  parameter  int WIDTH  = 32,
  localparam int NSLICE = WIDTH / 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
`ifdef BSA_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] data_result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [NSLICE-1:0][7:0] a_q;
  logic [NSLICE-1:0][7:0] b_q;
  logic [NSLICE-1:0][7:0] res_q;
  logic [IW-1:0]          idx_q;
  logic                   cy_q;

  logic [7:0] sa, sb, sg, sp, sum;
  logic [8:0] sc;
  logic       accept, last, kill, ovf;

`ifdef BSA_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign accept      = (state_q == IDLE) && start;
  assign last        = (idx_q == IW'(NSLICE - 1));
  assign ready       = (state_q == IDLE);
  assign done        = (state_q == FIN);
  assign data_result = res_q;

  // Shared slice: generate/propagate lookahead over one byte
  always_comb begin
    sa = a_q[idx_q];
    sb = b_q[idx_q];
    sg = sa & sb;
    sp = sa ^ sb;
    sc = '0;
    sc[0] = cy_q;
    for (int i = 0; i < 8; i++) begin
      sc[i+1] = sg[i] | (sp[i] & sc[i]);
    end
    sum = sp ^ sc[7:0];
    ovf = (sa[7] == sb[7]) && (sum[7] != sa[7]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (kill)      state_d = IDLE;
        else if (last) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      cy_q      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q       <= data_operandA;
      b_q       <= op_sub ? ~data_operandB
                          : data_operandB;
      cy_q      <= op_sub;
      idx_q     <= '0;
      res_q     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state_q == RUN) begin
      if (kill) begin
        res_q     <= '0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        res_q[idx_q] <= sum;
        cy_q         <= sc[8];
        idx_q        <= idx_q + 1'b1;
        if (last) begin
          carry_out <= sc[8];
          overflow  <= ovf;
        end
      end
    end
  end

endmodule
